judge_sprite_drawer: RTL and testbench

JUDGE_SPRITE_DRAWER -- requirements
Module: judge_sprite_drawer

---
 rtl/judge_sprite_drawer_if.sv | 27 ++
 rtl/judge_sprite_drawer.sv | 157 +++++++++++++++
 tb/tb_judge_sprite_drawer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/judge_sprite_drawer_if.sv
// Pixel bus between the judgement sprite drawer and its surroundings.
//   accuracy : judgement code from the datapath (00 n/a, 01 perfect, 10 good, 11 miss)
//   x, y     : pixel coordinate to the VGA adapter
//   colour   : 3-bit pixel colour
//   plot     : pixel write strobe
//   busy     : drawer is sweeping (drawing or clearing)
//   done     : one-cycle pulse on the last pixel of a sweep
// master = the drawer, slave = the datapath / VGA side.
interface judge_sprite_drawer_if;
    logic [1:0] accuracy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        input  accuracy,
        output x, y, colour, plot, busy, done
    );

    modport slave (
        output accuracy,
        input  x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/judge_sprite_drawer.sv
// Draws an 8x8 judgement glyph (perfect / good / miss) at (X0, Y0) whenever
// the accuracy code changes, keeps it on screen for HOLD_CYCLES idle cycles,
// then sweeps the same 8x8 area with black.
// Ports:
//   clk : single system clock
//   rst : synchronous, active-low reset
//   bus : judge_sprite_drawer_if.master (accuracy in; x, y, colour, plot,
//         busy, done out; x/y/colour/plot/done are registered)
module judge_sprite_drawer #(
    parameter logic [7:0]  X0            = 8'd76,
    parameter logic [6:0]  Y0            = 7'd56,
    parameter logic [23:0] HOLD_CYCLES   = 24'd12500000,
    parameter logic [63:0] GLYPH_PERFECT = 64'h0006063E66663E00,
    parameter logic [63:0] GLYPH_GOOD    = 64'h3C66067666663C00,
    parameter logic [63:0] GLYPH_MISS    = 64'h0000663C183C6600
) (
    input  logic clk,
    input  logic rst,
    judge_sprite_drawer_if.master bus
);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD, CLEAR} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  code_reg, code_next;
    logic [5:0]  pix_reg, pix_next;
    logic [23:0] hold_reg, hold_next;
    logic [7:0]  x_reg, x_next;
    logic [6:0]  y_reg, y_next;
    logic [2:0]  colour_reg, colour_next;
    logic        plot_reg, plot_next;
    logic        done_reg, done_next;

    // Pixel emitted on this edge: pix_reg always names the pixel currently
    // shown on the outputs, so the emitted index and pix_next coincide.
    logic        emit;
    logic        emit_clear;
    logic [1:0]  emit_code;
    logic [5:0]  emit_pix;

    // The glyph bit index 8*row+col is exactly the row-major pixel index.
    function automatic logic [2:0] glyph_colour(input logic [1:0] code,
                                                input logic [5:0] idx);
        logic [2:0] c;
        c = 3'b000;
        case (code)
            2'b01:   c = GLYPH_PERFECT[idx] ? 3'b010 : 3'b000;
            2'b10:   c = GLYPH_GOOD[idx]    ? 3'b001 : 3'b000;
            2'b11:   c = GLYPH_MISS[idx]    ? 3'b100 : 3'b000;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    always_comb begin
        state_next  = state_reg;
        code_next   = code_reg;
        pix_next    = pix_reg;
        hold_next   = hold_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = 3'b000;
        plot_next   = 1'b0;
        done_next   = 1'b0;
        emit        = 1'b0;
        emit_clear  = 1'b0;
        emit_code   = code_reg;
        emit_pix    = 6'd0;

        if (bus.accuracy != code_reg) begin
            // A new judgement wins over everything, even mid-sweep or at
            // hold expiry; the abandoned sweep gets no done pulse.
            code_next  = bus.accuracy;
            emit_code  = bus.accuracy;
            state_next = DRAW;
            pix_next   = 6'd0;
            emit       = 1'b1;
            emit_pix   = 6'd0;
        end else begin
            case (state_reg)
                DRAW: begin
                    if (pix_reg == 6'd63) begin
                        state_next = (code_reg != 2'b00) ? HOLD : IDLE;
                        hold_next  = 24'd0;
                    end else begin
                        pix_next = pix_reg + 6'd1;
                        emit     = 1'b1;
                        emit_pix = pix_reg + 6'd1;
                    end
                end
                HOLD: begin
                    if (hold_reg == HOLD_CYCLES - 24'd1) begin
                        state_next = CLEAR;
                        pix_next   = 6'd0;
                        emit       = 1'b1;
                        emit_clear = 1'b1;
                        emit_pix   = 6'd0;
                    end else begin
                        hold_next = hold_reg + 24'd1;
                    end
                end
                CLEAR: begin
                    if (pix_reg == 6'd63) begin
                        state_next = IDLE;
                    end else begin
                        pix_next   = pix_reg + 6'd1;
                        emit       = 1'b1;
                        emit_clear = 1'b1;
                        emit_pix   = pix_reg + 6'd1;
                    end
                end
                default: ;
            endcase
        end

        if (emit) begin
            plot_next   = 1'b1;
            x_next      = X0 + {5'b00000, emit_pix[2:0]};
            y_next      = Y0 + {4'b0000, emit_pix[5:3]};
            colour_next = emit_clear ? 3'b000 : glyph_colour(emit_code, emit_pix);
            done_next   = (emit_pix == 6'd63);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            code_reg   <= 2'b00;
            pix_reg    <= 6'd0;
            hold_reg   <= 24'd0;
            x_reg      <= 8'd0;
            y_reg      <= 7'd0;
            colour_reg <= 3'b000;
            plot_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            code_reg   <= code_next;
            pix_reg    <= pix_next;
            hold_reg   <= hold_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            colour_reg <= colour_next;
            plot_reg   <= plot_next;
            done_reg   <= done_next;
        end
    end

    // The state register already tracks the sweep cycle-for-cycle with plot.
    assign bus.busy   = (state_reg == DRAW) || (state_reg == CLEAR);
    assign bus.x      = x_reg;
    assign bus.y      = y_reg;
    assign bus.colour = colour_reg;
    assign bus.plot   = plot_reg;
    assign bus.done   = done_reg;

endmodule

// File: tb/tb_judge_sprite_drawer.sv
// Directed testbench for judge_sprite_drawer (HOLD_CYCLES = 4).
// Instance dut drives the default position; dut_w sits at X0 = 254 to
// exercise x wrap-around. Outputs are sampled 1 ns after each rising edge.
module tb_judge_sprite_drawer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    logic [63:0] g_perf = 64'h0006063E66663E00;
    logic [63:0] g_good = 64'h3C66067666663C00;
    logic [63:0] g_miss = 64'h0000663C183C6600;

    judge_sprite_drawer_if bus_a ();
    judge_sprite_drawer_if bus_w ();

    judge_sprite_drawer #(.HOLD_CYCLES(24'd4)) dut (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    judge_sprite_drawer #(.X0(8'd254), .HOLD_CYCLES(24'd4)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_a.accuracy = 2'b00;
        bus_w.accuracy = 2'b00;
        rst = 1'b0;
        tick();
        tick();
        compared++;
        if ({bus_a.plot, bus_a.busy, bus_a.done} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_ctrl: plot/busy/done=%b required 000", {bus_a.plot, bus_a.busy, bus_a.done});
        end
        compared++;
        if ({bus_a.x, bus_a.y, bus_a.colour} !== 18'd0) begin
            mismatched++;
            $display("FAIL reset_xyc: x=%0d y=%0d colour=%b required 0 0 000", bus_a.x, bus_a.y, bus_a.colour);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (bus_a.plot !== 1'b0 || bus_a.busy !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_idle00: cycle %0d plot=%b busy=%b required 0 0", i, bus_a.plot, bus_a.busy);
            end
        end
        $display("test_reset: done");
    endtask

    // 00 -> 01 draws the perfect glyph and ends with done on the 64th cycle.
    task automatic test_draw();
        logic [2:0] exp_c;
        bus_a.accuracy = 2'b01;
        for (int i = 0; i < 64; i++) begin
            tick();
            exp_c = g_perf[i] ? 3'b010 : 3'b000;
            compared++;
            if (bus_a.plot !== 1'b1 || bus_a.busy !== 1'b1 || bus_a.done !== (i == 63)
                || bus_a.x !== 8'(76 + i % 8) || bus_a.y !== 7'(56 + i / 8)
                || bus_a.colour !== exp_c) begin
                mismatched++;
                $display("FAIL draw_pix%0d: plot=%b busy=%b done=%b x=%0d y=%0d c=%b required 1 1 %b %0d %0d %b",
                         i, bus_a.plot, bus_a.busy, bus_a.done, bus_a.x, bus_a.y, bus_a.colour,
                         (i == 63), 76 + i % 8, 56 + i / 8, exp_c);
            end
        end
        $display("test_draw: perfect sweep checked");
    endtask

    // Same code held: 4 idle cycles, then a black clear sweep, then silence.
    task automatic test_hold_clear();
        for (int i = 0; i < 4; i++) begin
            tick();
            compared++;
            if (bus_a.plot !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0
                || bus_a.x !== 8'd83 || bus_a.y !== 7'd63) begin
                mismatched++;
                $display("FAIL hold_cyc%0d: plot=%b busy=%b done=%b x=%0d y=%0d required 0 0 0 83 63",
                         i, bus_a.plot, bus_a.busy, bus_a.done, bus_a.x, bus_a.y);
            end
        end
        for (int i = 0; i < 64; i++) begin
            tick();
            compared++;
            if (bus_a.plot !== 1'b1 || bus_a.busy !== 1'b1 || bus_a.done !== (i == 63)
                || bus_a.x !== 8'(76 + i % 8) || bus_a.y !== 7'(56 + i / 8)
                || bus_a.colour !== 3'b000) begin
                mismatched++;
                $display("FAIL clear_pix%0d: plot=%b done=%b x=%0d y=%0d c=%b required 1 %b %0d %0d 000",
                         i, bus_a.plot, bus_a.done, bus_a.x, bus_a.y, bus_a.colour,
                         (i == 63), 76 + i % 8, 56 + i / 8);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            compared++;
            if (bus_a.plot !== 1'b0 || bus_a.busy !== 1'b0) begin
                mismatched++;
                $display("FAIL after_clear%0d: plot=%b busy=%b required 0 0", i, bus_a.plot, bus_a.busy);
            end
        end
        $display("test_hold_clear: hold and clear checked");
    endtask

    // 01 -> 11 at pix 20 abandons the sweep and restarts with the miss glyph.
    task automatic test_abort();
        logic [2:0] exp_c;
        rst = 1'b0;
        bus_a.accuracy = 2'b00;
        tick();
        rst = 1'b1;
        bus_a.accuracy = 2'b01;
        for (int i = 0; i <= 20; i++) begin
            tick();
            compared++;
            if (bus_a.plot !== 1'b1 || bus_a.done !== 1'b0) begin
                mismatched++;
                $display("FAIL abort_pre%0d: plot=%b done=%b required 1 0", i, bus_a.plot, bus_a.done);
            end
        end
        bus_a.accuracy = 2'b11;
        for (int i = 0; i < 64; i++) begin
            tick();
            exp_c = g_miss[i] ? 3'b100 : 3'b000;
            compared++;
            if (bus_a.plot !== 1'b1 || bus_a.done !== (i == 63)
                || bus_a.x !== 8'(76 + i % 8) || bus_a.y !== 7'(56 + i / 8)
                || bus_a.colour !== exp_c) begin
                mismatched++;
                $display("FAIL miss_pix%0d: plot=%b done=%b x=%0d y=%0d c=%b required 1 %b %0d %0d %b",
                         i, bus_a.plot, bus_a.done, bus_a.x, bus_a.y, bus_a.colour,
                         (i == 63), 76 + i % 8, 56 + i / 8, exp_c);
            end
            if (i == 9) begin
                compared++;
                if (bus_a.colour !== 3'b100) begin
                    mismatched++;
                    $display("FAIL miss_c1r1: colour=%b required 100", bus_a.colour);
                end
            end
        end
        $display("test_abort: restart with miss glyph checked");
    endtask

    // Reset mid-sweep clears outputs; held code 10 then starts a fresh sweep.
    task automatic test_reset_mid();
        logic [2:0] exp_c;
        bus_a.accuracy = 2'b10;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b0;
        tick();
        compared++;
        if ({bus_a.plot, bus_a.busy, bus_a.done, bus_a.colour} !== 6'd0
            || bus_a.x !== 8'd0 || bus_a.y !== 7'd0) begin
            mismatched++;
            $display("FAIL reset_mid: plot=%b busy=%b x=%0d y=%0d required 0 0 0 0",
                     bus_a.plot, bus_a.busy, bus_a.x, bus_a.y);
        end
        rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            exp_c = g_good[i] ? 3'b001 : 3'b000;
            compared++;
            if (bus_a.plot !== 1'b1 || bus_a.done !== (i == 63)
                || bus_a.x !== 8'(76 + i % 8) || bus_a.y !== 7'(56 + i / 8)
                || bus_a.colour !== exp_c) begin
                mismatched++;
                $display("FAIL good_pix%0d: plot=%b done=%b x=%0d y=%0d c=%b required 1 %b %0d %0d %b",
                         i, bus_a.plot, bus_a.done, bus_a.x, bus_a.y, bus_a.colour,
                         (i == 63), 76 + i % 8, 56 + i / 8, exp_c);
            end
        end
        $display("test_reset_mid: fresh good sweep checked");
    endtask

    // X0 = 254: each row runs 254, 255, 0 .. 5.
    task automatic test_wrap();
        bus_w.accuracy = 2'b01;
        for (int i = 0; i < 64; i++) begin
            tick();
            compared++;
            if (bus_w.plot !== 1'b1 || bus_w.x !== 8'(254 + i % 8) || bus_w.y !== 7'(56 + i / 8)) begin
                mismatched++;
                $display("FAIL wrap_pix%0d: plot=%b x=%0d y=%0d required 1 %0d %0d",
                         i, bus_w.plot, bus_w.x, bus_w.y, (254 + i % 8) % 256, 56 + i / 8);
            end
        end
        $display("test_wrap: x wrap checked");
    endtask

    initial begin
        test_reset();
        test_draw();
        test_hold_clear();
        test_abort();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
